// File: rtl/tdm_demux4_collector_pkg.sv
// Shared definitions for the TDM 4:1 demux collector.
// Contents: FSM state encoding, last-slot constant, SETTLE upper bound.
package tdm_demux4_collector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } fsm_state_t;

    localparam logic [1:0] SLOT_LAST  = 2'd3;
    localparam int         SETTLE_MAX = 15;

endpackage

// File: rtl/tdm_demux4_collector_slot_sequencer.sv
// Slot sequencer for the TDM 4:1 demux collector.
// Steps the mux select lines through slots 0..3. After each select change it
// waits SETTLE cycles, then strobes a sample.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, auto_run   frame start (level, seen in IDLE) / continuous framing
//   sel_a, sel_b      registered mux selects (= slot bits 0/1)
//   g_n               registered active-low mux enable
//   sample_en         high in the cycle whose closing edge captures y_in
//   slot              slot being sampled while sample_en is high
//   frame_done        high in the cycle whose closing edge samples the last slot
//   busy              high whenever the FSM is not IDLE
module tdm_demux4_collector_slot_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       auto_run,
    output logic       sel_a,
    output logic       sel_b,
    output logic       g_n,
    output logic       sample_en,
    output logic [1:0] slot,
    output logic       frame_done,
    output logic       busy
);
    import tdm_demux4_collector_pkg::*;

    if (SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_settle_range
        $error("SETTLE must be in the range 0..15");
    end

    // With SETTLE=0 the WAIT state is bypassed entirely.
    localparam fsm_state_t FIRST_ST    = fsm_state_t'((SETTLE == 0) ? SAMPLE : WAIT);
    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    fsm_state_t state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic [3:0] settle_q, settle_d;
    logic       g_n_q, g_n_d;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        settle_d = settle_q;
        g_n_d    = g_n_q;
        case (state_q)
            IDLE: begin
                slot_d = 2'd0;
                g_n_d  = 1'b1;
                if (start) begin
                    state_d  = FIRST_ST;
                    g_n_d    = 1'b0;
                    settle_d = 4'd0;
                end
            end
            WAIT: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SETTLE_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                // Slot 3 wraps to 0 on the way into DONE.
                slot_d   = slot_q + 2'd1;
                settle_d = 4'd0;
                state_d  = (slot_q == SLOT_LAST) ? DONE : FIRST_ST;
            end
            DONE: begin
                if (auto_run) begin
                    state_d  = FIRST_ST;
                    settle_d = 4'd0;
                end else begin
                    state_d = IDLE;
                    g_n_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            slot_q   <= 2'd0;
            settle_q <= 4'd0;
            g_n_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            settle_q <= settle_d;
            g_n_q    <= g_n_d;
        end
    end

    // Selects come straight from the slot flop, so they are registered and
    // stay put through the SAMPLE cycle.
    assign sel_a      = slot_q[0];
    assign sel_b      = slot_q[1];
    assign g_n        = g_n_q;
    assign slot       = slot_q;
    assign sample_en  = (state_q == SAMPLE);
    assign frame_done = sample_en && (slot_q == SLOT_LAST);
    assign busy       = (state_q != IDLE);

endmodule

// File: rtl/tdm_demux4_collector.sv
// TDM 4:1 demux collector: the receive-side partner of a (dual) 4:1 mux.
// Drives the mux selects and enable, samples y_in once per slot, and
// publishes all four slot values together on d0..d3 with a done pulse.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, auto_run      frame start / continuous framing
//   y_in[WIDTH]          mux output(s)
//   sel_a, sel_b, g_n    mux control, registered
//   d0..d3[WIDTH]        slot values, updated atomically once per frame
//   done                 one-cycle pulse coincident with the d0..d3 update
//   busy                 high when not IDLE
module tdm_demux4_collector #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             auto_run,
    input  logic [WIDTH-1:0] y_in,
    output logic             sel_a,
    output logic             sel_b,
    output logic             g_n,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic             done,
    output logic             busy
);
    import tdm_demux4_collector_pkg::*;

    logic       sample_en;
    logic       frame_done;
    logic [1:0] slot;

    tdm_demux4_collector_slot_sequencer #(
        .SETTLE (SETTLE)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .auto_run   (auto_run),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .g_n        (g_n),
        .sample_en  (sample_en),
        .slot       (slot),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Only slots 0..2 need shadowing: slot 3 goes straight from y_in into d3
    // on the same edge that publishes the frame, so done lands in the DONE
    // cycle together with the new data.
    logic [2:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [3:0][WIDTH-1:0] d_q, d_d;
    logic                  done_q, done_d;

    always_comb begin
        shadow_d = shadow_q;
        d_d      = d_q;
        done_d   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sample_en && slot == 2'(i)) shadow_d[i] = y_in;
        end
        if (frame_done) begin
            d_d    = {y_in, shadow_q[2], shadow_q[1], shadow_q[0]};
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            d_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            d_q      <= d_d;
            done_q   <= done_d;
        end
    end

    assign d0   = d_q[0];
    assign d1   = d_q[1];
    assign d2   = d_q[2];
    assign d3   = d_q[3];
    assign done = done_q;

endmodule

// File: tb/tb_tdm_demux4_collector.sv
// Bench for tdm_demux4_collector: two instances (WIDTH=1/SETTLE=1 and
// WIDTH=2/SETTLE=0) looped back through a behavioural dual 4:1 mux.
module tb_tdm_demux4_collector;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: WIDTH=1, SETTLE=1
    logic       start_a, auto_a;
    logic [3:0] da;
    logic       ya, sel_a_a, sel_b_a, g_n_a, done_a, busy_a;
    logic       d0_a, d1_a, d2_a, d3_a;
    assign ya = g_n_a ? 1'b0 : da[{sel_b_a, sel_a_a}];

    tdm_demux4_collector #(.WIDTH(1), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .auto_run(auto_a), .y_in(ya),
        .sel_a(sel_a_a), .sel_b(sel_b_a), .g_n(g_n_a),
        .d0(d0_a), .d1(d1_a), .d2(d2_a), .d3(d3_a), .done(done_a), .busy(busy_a)
    );

    // instance B: WIDTH=2, SETTLE=0, both mux sections
    logic       start_b, auto_b;
    logic [3:0] db0, db1;
    logic [1:0] yb, d0_b, d1_b, d2_b, d3_b;
    logic       sel_a_b, sel_b_b, g_n_b, done_b, busy_b;
    assign yb = g_n_b ? 2'b00 : {db1[{sel_b_b, sel_a_b}], db0[{sel_b_b, sel_a_b}]};

    tdm_demux4_collector #(.WIDTH(2), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .auto_run(auto_b), .y_in(yb),
        .sel_a(sel_a_b), .sel_b(sel_b_b), .g_n(g_n_b),
        .d0(d0_b), .d1(d1_b), .d2(d2_b), .d3(d3_b), .done(done_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done_a = 0;
    int   n_done_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_b(input logic [3:0] s1, input logic [3:0] s0);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) r[2*i +: 2] = {s1[i], s0[i]};
        return r;
    endfunction

    // Advance one cycle and score any done pulse against the queues.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done_a) begin
            n_done_a++;
            if (q_a.size() == 0) chk("a_spurious_done", 1, 0);
            else begin
                e = q_a.pop_front();
                chk("a_data", {4'h0, d3_a, d2_a, d1_a, d0_a}, e.data);
                chk("a_latency", cyc, e.cyc);
            end
        end
        if (done_b) begin
            n_done_b++;
            if (q_b.size() == 0) chk("b_spurious_done", 1, 0);
            else begin
                e = q_b.pop_front();
                chk("b_data", {d3_b, d2_b, d1_b, d0_b}, e.data);
                chk("b_latency", cyc, e.cyc);
            end
        end
    endtask

    task automatic push_a(input logic [3:0] d, input int c);
        exp_t e;
        e.data = {4'h0, d};
        e.cyc  = c;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        q_b.push_back(e);
    endtask

    int  c0, nd, gn_hi;
    bit  got;

    initial begin
        rst = 1'b1; start_a = 0; start_b = 0; auto_a = 0; auto_b = 0;
        da = '0; db0 = '0; db1 = '0;
        repeat (3) tick();
        rst = 1'b0;

        // reset / idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("a_idle", {g_n_a, sel_b_a, sel_a_a, done_a, busy_a, d3_a, d2_a, d1_a, d0_a}, 9'h100);
            chk("b_idle", {g_n_b, sel_b_b, sel_a_b, done_b, busy_b, d3_b, d2_b, d1_b, d0_b}, 13'h1000);
        end

        // single frame, D3..D0 = 1,0,1,1
        da = 4'b1011; c0 = cyc; nd = n_done_a;
        push_a(4'b1011, c0 + 9);
        start_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) start_a = 1'b0;
            if (k <= 8) begin
                chk("a_sel_seq", {sel_b_a, sel_a_a}, (k - 1) / 2);
                chk("a_gn_active", g_n_a, 0);
            end
        end
        chk("a_gn_return", g_n_a, 1);
        chk("a_one_done", n_done_a - nd, 1);

        // SETTLE=0, auto_run, three back-to-back frames with changing data
        auto_b = 1'b1; db1 = 4'b1001; db0 = 4'b0110; c0 = cyc;
        push_b(exp_b(db1, db0), c0 + 5);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        gn_hi = 0;
        for (int f = 0; f < 3; f++) begin
            got = 0;
            for (int t = 0; t < 8 && !got; t++) begin
                tick();
                if (g_n_b) gn_hi++;
                if (done_b) got = 1;
            end
            if (!got) chk("b_done_timeout", 0, 1);
            if (f == 0) begin
                db1 = 4'b0011; db0 = 4'b1100; push_b(exp_b(db1, db0), cyc + 5);
            end else if (f == 1) begin
                db1 = 4'b1111; db0 = 4'b0101; push_b(exp_b(db1, db0), cyc + 5);
            end else auto_b = 1'b0;
        end
        chk("b_gn_stayed_low", gn_hi, 0);
        tick(); tick();
        chk("b_back_idle", {g_n_b, busy_b}, 2'b10);

        // start re-asserted mid-frame (slot 2) is ignored
        da = 4'b0110; c0 = cyc; nd = n_done_a;
        push_a(4'b0110, c0 + 9);
        start_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) start_a = 1'b0;
            if (k == 5) start_a = 1'b1;
            if (k == 7) start_a = 1'b0;
        end
        chk("a_midstart_one_done", n_done_a - nd, 1);
        chk("a_midstart_idle", {g_n_a, busy_a}, 2'b10);

        // reset mid-frame: load 1010 first, abort the next frame at slot 1
        da = 4'b1010; c0 = cyc;
        push_a(4'b1010, c0 + 9);
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        repeat (10) tick();
        chk("a_prior_d", {d3_a, d2_a, d1_a, d0_a}, 4'b1010);
        da = 4'b0101; nd = n_done_a;
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        tick(); tick();
        chk("a_abort_slot", {g_n_a, sel_b_a, sel_a_a}, 3'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("a_rst_d", {d3_a, d2_a, d1_a, d0_a}, 4'b0000);
        chk("a_rst_ctrl", {g_n_a, busy_a, done_a}, 3'b100);
        repeat (12) tick();
        chk("a_rst_no_done", n_done_a - nd, 0);
        c0 = cyc; nd = n_done_a;
        push_a(4'b0101, c0 + 9);
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        repeat (10) tick();
        chk("a_clean_frame", n_done_a - nd, 1);

        // start held high, auto_run=0: frames 10 cycles apart
        da = 4'b1100; c0 = cyc; nd = 0; gn_hi = 0;
        push_a(4'b1100, c0 + 9);
        push_a(4'b1100, c0 + 19);
        push_a(4'b1100, c0 + 29);
        start_a = 1'b1;
        for (int t = 0; t < 40 && nd < 3; t++) begin
            tick();
            if (done_a) begin
                nd++;
                if (nd == 3) start_a = 1'b0;
            end else if (nd == 1 && g_n_a) gn_hi++;
        end
        chk("a_held_dones", nd, 3);
        chk("a_held_idle_gap", gn_hi, 1);
        repeat (3) tick();
        chk("a_held_end_idle", {g_n_a, busy_a}, 2'b10);

        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
